// File: rtl/knn_feeder.sv
// knn_feeder: owns the test/data/result buffers and streams every (test, data)
// pair into the KNN core, capturing one knn_info result per test point.
module knn_feeder #(
  parameter int DATA_W    = 32,
  parameter int NBR_TESTP = 4,
  parameter int NBR_DATAP = 10,
  parameter int DRAIN_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [7:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              clr_o,
  output logic              valid_o,
  output logic              last_o,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  input  logic [7:0]        knn_info,
  input  logic [7:0]        rd_addr,
  output logic [7:0]        rd_data
);

  localparam int TW = (NBR_TESTP > 1) ? $clog2(NBR_TESTP) : 1;
  localparam int DW = (NBR_DATAP > 1) ? $clog2(NBR_DATAP) : 1;
  localparam int KW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  localparam logic [7:0]    TP_LAST = 8'(NBR_TESTP - 1);
  localparam logic [7:0]    DP_LAST = 8'(NBR_DATAP - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(NBR_TESTP - 1);
  localparam logic [DW-1:0] D_LAST  = DW'(NBR_DATAP - 1);
  localparam logic [KW-1:0] K_LAST  = KW'(DRAIN_CYC - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]        state;
  logic [DATA_W-1:0] tp  [NBR_TESTP];
  logic [DATA_W-1:0] dp  [NBR_DATAP];
  logic [7:0]        res [NBR_TESTP];
  logic [TW-1:0]     t;
  logic [DW-1:0]     d;
  logic [KW-1:0]     k;
  logic [DW-1:0]     d_nxt;

  assign d_nxt = d + DW'(1);

  // Outputs are registered from the next-state decision, so each output
  // is aligned with the state the FSM occupies during that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      t       <= '0;
      d       <= '0;
      k       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      clr_o   <= 1'b0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      A       <= '0;
      B       <= '0;
      // NOTE: the buffers are flops, not RAM macros, so clearing them in reset is legal and required here.
      for (int i = 0; i < NBR_TESTP; i++) begin
        tp[i]  <= '0;
        res[i] <= '0;
      end
      for (int i = 0; i < NBR_DATAP; i++) begin
        dp[i] <= '0;
      end
    end else begin
      if (wr_en && !busy) begin
        if (!wr_sel && (wr_addr <= TP_LAST)) tp[wr_addr[TW-1:0]] <= wr_data;
        if (wr_sel  && (wr_addr <= DP_LAST)) dp[wr_addr[DW-1:0]] <= wr_data;
      end

      // NOTE: pulse defaults use <= like all state here; a later <= in the case below overrides them.
      clr_o   <= 1'b0;
      valid_o <= 1'b0;
      last_o  <= 1'b0;

      if (en) begin
        case (state)
          S_IDLE, S_DONE: begin
            if (start) begin
              state <= S_CLEAR;
              t     <= '0;
              done  <= 1'b0;
              busy  <= 1'b1;
              clr_o <= 1'b1;
            end
          end
          S_CLEAR: begin
            state   <= S_STREAM;
            d       <= '0;
            valid_o <= 1'b1;
            last_o  <= (D_LAST == '0);
            A       <= tp[t];
            B       <= dp[0];
          end
          S_STREAM: begin
            if (d == D_LAST) begin
              state <= S_DRAIN;
              k     <= '0;
            end else begin
              d       <= d_nxt;
              valid_o <= 1'b1;
              last_o  <= (d_nxt == D_LAST);
              B       <= dp[d_nxt];
            end
          end
          S_DRAIN: begin
            if (k == K_LAST) begin
              res[t] <= knn_info;
              if (t == T_LAST) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                t     <= t + TW'(1);
                state <= S_CLEAR;
                clr_o <= 1'b1;
              end
            end else begin
              k <= k + KW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign rd_data = (rd_addr <= TP_LAST) ? res[rd_addr[TW-1:0]] : 8'h00;

endmodule
